// File: rtl/logical_pkg.sv
// Shared opcode and precision encodings
// for the SIMD lane logical unit.
package logical_pkg;

  localparam logic [3:0] OP_AND       = 4'h0;
  localparam logic [3:0] OP_OR        = 4'h1;
  localparam logic [3:0] OP_XOR       = 4'h2;
  localparam logic [3:0] OP_NOT       = 4'h3;
  localparam logic [3:0] OP_COPY      = 4'h4;
  localparam logic [3:0] OP_SEL_GT    = 4'h5;
  localparam logic [3:0] OP_SEL_EQ    = 4'h6;
  localparam logic [3:0] OP_SEL_LS    = 4'h7;
  localparam logic [3:0] OP_LSHIFT    = 4'h8;
  localparam logic [3:0] OP_ASHIFT    = 4'h9;
  localparam logic [3:0] OP_ROT_SHIFT = 4'hA;

  localparam logic PREC_16 = 1'b0;
  localparam logic PREC_32 = 1'b1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic is_shift(
    input logic [3:0] op
  );
    return (op == OP_LSHIFT) ||
           (op == OP_ASHIFT) ||
           (op == OP_ROT_SHIFT);
  endfunction

endpackage

// File: rtl/logical_unit_shifter.sv
// Combinational shift/rotate datapath;
// result is already width-adjusted.
module logical_shifter
  import logical_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  input  logic        dir,
  input  logic [3:0]  op,
  input  logic        prec,
  output logic [31:0] result
);

  logic [4:0]  a;
  logic [5:0]  ra32;
  logic [4:0]  ra16;
  logic [15:0] d16;
  logic [31:0] lsl32, lsr32, asr32, rot32;
  logic [15:0] lsl16, lsr16, asr16, rot16;
  logic        is_l, is_a, is_r;

  assign a    = (prec == PREC_32) ? amt
                                  : {1'b0, amt[3:0]};
  assign ra32 = 6'd32 - {1'b0, a};
  assign ra16 = 5'd16 - a;
  assign d16  = data[15:0];

  assign lsl32 = data << a;
  assign lsr32 = data >> a;
  assign asr32 = $signed(data) >>> a;
  assign rot32 = (data >> a) | (data << ra32);

  assign lsl16 = d16 << a;
  assign lsr16 = d16 >> a;
  assign asr16 = $signed(d16) >>> a;
  assign rot16 = (d16 >> a) | (d16 << ra16);

  assign is_l = (op == OP_LSHIFT);
  assign is_a = (op == OP_ASHIFT);
  assign is_r = (op == OP_ROT_SHIFT);

  // Pick shift flavour; 16b arith right sign-extends
  always_comb begin
    result = 32'h0;
    unique case (1'b1)
      is_l: begin
        if (prec == PREC_32)
          result = dir ? lsr32 : lsl32;
        else
          result = {16'h0, dir ? lsr16 : lsl16};
      end
      is_a: begin
        if (prec == PREC_32)
          result = dir ? asr32 : lsl32;
        else if (dir == DIR_RIGHT)
          result = {{16{asr16[15]}}, asr16};
        else
          result = {16'h0, lsl16};
      end
      is_r: begin
        if (prec == PREC_32)
          result = rot32;
        else
          result = {16'h0, rot16};
      end
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/logical_unit.sv
// Single-cycle bitwise/select/shift unit
// for a SIMD lane; registered outputs.
module logical_unit
  import logical_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        logical_vld_i,
  input  logic [3:0]  logical_op_i,
  input  logic        logical_precision_i,
  input  logic [31:0] logical_src0_i,
  input  logic [31:0] logical_src1_i,
  input  logic [2:0]  fpadd_status_i,
  input  logic        shift_dir_i,
  output logic        logical_done_o,
  output logic [31:0] logical_dst_o
);

  logic [31:0] s0, s1;
  logic [31:0] lres, lmask, sres, res;

  assign s0 = logical_src0_i;
  assign s1 = logical_src1_i;

  logical_shifter u_shift (
    .data   (s0),
    .amt    (s1[4:0]),
    .dir    (shift_dir_i),
    .op     (logical_op_i),
    .prec   (logical_precision_i),
    .result (sres)
  );

  // Bitwise and flag-driven select ops
  always_comb begin
    lres = 32'h0;
    case (logical_op_i)
      OP_AND:    lres = s0 & s1;
      OP_OR:     lres = s0 | s1;
      OP_XOR:    lres = s0 ^ s1;
      OP_NOT:    lres = ~s0;
      OP_COPY:   lres = s0;
      OP_SEL_GT: lres = fpadd_status_i[2] ? s0 : s1;
      OP_SEL_EQ: lres = fpadd_status_i[1] ? s0 : s1;
      OP_SEL_LS: lres = fpadd_status_i[0] ? s0 : s1;
      default:   lres = 32'h0;
    endcase
  end

  assign lmask = (logical_precision_i == PREC_32)
               ? lres : {16'h0, lres[15:0]};
  assign res   = is_shift(logical_op_i) ? sres
                                        : lmask;

  // Capture result and pulse done per valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logical_done_o <= 1'b0;
      logical_dst_o  <= 32'h0;
    end else begin
      logical_done_o <= logical_vld_i;
      if (logical_vld_i)
        logical_dst_o <= res;
    end
  end

endmodule

// File: tb/tb_logical_unit.sv
// Directed bench for logical_unit
// with hand-computed vectors.
module tb_logical_unit;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic [3:0]  op;
  logic        prec;
  logic [31:0] src0, src1;
  logic [2:0]  status;
  logic        dir;
  logic        done;
  logic [31:0] dst;

  int total;
  int bad;

  logical_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .logical_vld_i       (vld),
    .logical_op_i        (op),
    .logical_precision_i (prec),
    .logical_src0_i      (src0),
    .logical_src1_i      (src1),
    .fpadd_status_i      (status),
    .shift_dir_i         (dir),
    .logical_done_o      (done),
    .logical_dst_o       (dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic run(
    input string       tag,
    input logic [3:0]  o,
    input logic        p,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  st,
    input logic        d,
    input logic [31:0] exp
  );
    @(negedge clk);
    vld    = 1'b1;
    op     = o;
    prec   = p;
    src0   = a;
    src1   = b;
    status = st;
    dir    = d;
    @(posedge clk);
    #1;
    check({tag, "_dst"}, dst, exp);
    check({tag, "_done"}, {31'h0, done}, 32'h1);
  endtask

  task automatic idle(
    input string       tag,
    input logic [31:0] held
  );
    @(negedge clk);
    vld  = 1'b0;
    src0 = 32'hDEAD_BEEF;
    src1 = 32'h0000_0001;
    op   = 4'h0;
    @(posedge clk);
    #1;
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_hold"}, dst, held);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    vld    = 1'b0;
    op     = 4'h0;
    prec   = 1'b1;
    src0   = 32'h0;
    src1   = 32'h0;
    status = 3'b000;
    dir    = 1'b0;
    #1;
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_dst", dst, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("sel_gt", 4'h5, 1'b1, 32'h4040_0000,
        32'h3F80_0000, 3'b100, 1'b0, 32'h4040_0000);
    idle("pulse", 32'h4040_0000);
    run("sel_ls_nan", 4'h7, 1'b1, 32'h4040_0000,
        32'h3F80_0000, 3'b000, 1'b0, 32'h3F80_0000);
    run("sel_eq_t", 4'h6, 1'b1, 32'h1111_1111,
        32'h2222_2222, 3'b010, 1'b0, 32'h1111_1111);
    run("sel_eq_f", 4'h6, 1'b1, 32'h1111_1111,
        32'h2222_2222, 3'b100, 1'b0, 32'h2222_2222);
    run("and16", 4'h0, 1'b0, 32'hA5A5_FFFF,
        32'h0F0F_1234, 3'b000, 1'b0, 32'h0000_1234);
    run("not32", 4'h3, 1'b1, 32'hA5A5_A5A5,
        32'h0, 3'b000, 1'b0, 32'h5A5A_5A5A);
    run("or32", 4'h1, 1'b1, 32'h1234_0000,
        32'h0000_5678, 3'b000, 1'b0, 32'h1234_5678);
    run("xor32", 4'h2, 1'b1, 32'hFFFF_0000,
        32'h0F0F_0F0F, 3'b000, 1'b0, 32'hF0F0_0F0F);
    run("copy16", 4'h4, 1'b0, 32'hDEAD_BEEF,
        32'h0, 3'b000, 1'b0, 32'h0000_BEEF);
    idle("idle1", 32'h0000_BEEF);

    run("lsl32", 4'h8, 1'b1, 32'hF0F0_F0F0,
        32'h4, 3'b000, 1'b0, 32'h0F0F_0F00);
    run("lsr32", 4'h8, 1'b1, 32'hF0F0_F0F0,
        32'h4, 3'b000, 1'b1, 32'h0F0F_0F0F);
    run("lsr31", 4'h8, 1'b1, 32'h8000_0000,
        32'h1F, 3'b000, 1'b1, 32'h0000_0001);
    run("lsl_hiamt", 4'h8, 1'b1, 32'hF0F0_F0F0,
        32'h24, 3'b000, 1'b0, 32'h0F0F_0F00);
    run("lsr16_hi", 4'h8, 1'b0, 32'hFFFF_F0F0,
        32'h14, 3'b000, 1'b1, 32'h0000_0F0F);
    run("asr32", 4'h9, 1'b1, 32'hF0F0_F0F0,
        32'h4, 3'b000, 1'b1, 32'hFF0F_0F0F);
    run("asr16", 4'h9, 1'b0, 32'h0000_8001,
        32'h1, 3'b000, 1'b1, 32'hFFFF_C000);
    run("asl16", 4'h9, 1'b0, 32'h0000_F0F0,
        32'h4, 3'b000, 1'b0, 32'h0000_0F00);

    run("rot32_8", 4'hA, 1'b1, 32'h1234_5678,
        32'h8, 3'b000, 1'b0, 32'h7812_3456);
    run("rot32_16", 4'hA, 1'b1, 32'h1234_5678,
        32'h10, 3'b000, 1'b1, 32'h5678_1234);
    run("rot32_0", 4'hA, 1'b1, 32'h1234_5678,
        32'h20, 3'b000, 1'b0, 32'h1234_5678);
    run("rot16_4", 4'hA, 1'b0, 32'hABCD_1234,
        32'h4, 3'b000, 1'b0, 32'h0000_4123);
    run("rot16_12", 4'hA, 1'b0, 32'h0000_1234,
        32'hC, 3'b000, 1'b1, 32'h0000_2341);

    run("op_f", 4'hF, 1'b1, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 3'b111, 1'b1, 32'h0);
    idle("idle2", 32'h0);

    run("pre_rst", 4'h4, 1'b1, 32'hCAFE_F00D,
        32'h0, 3'b000, 1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    vld  = 1'b1;
    op   = 4'h4;
    src0 = 32'h1357_9BDF;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_dst", dst, 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_done", {31'h0, done}, 32'h0);
    check("rst_edge_dst", dst, 32'h0);
    @(negedge clk);
    vld   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_done", {31'h0, done}, 32'h0);
    check("post_rst_dst", dst, 32'h0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
